// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file, one write port, two registered read ports
module reg_file_param #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 3,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              ren_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rvalid_a,
  input  logic              ren_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             wr_ok;
  logic [WIDTH:0]   next_a;
  logic [WIDTH:0]   next_b;

  // Value a read port loads on this edge, packed as {valid, data}.
  // Clear wins, then the hard-zero word 0, then same-cycle forwarding, then storage.
  function automatic logic [WIDTH:0] lookup(
    input logic [ADDR_W-1:0] addr,
    input logic [WIDTH-1:0]  word,
    input logic              vbit,
    input logic              wr,
    input logic [ADDR_W-1:0] wa,
    input logic [WIDTH-1:0]  wd,
    input logic              clr_i
  );
    logic [WIDTH:0] r;
    if (clr_i) begin
      r = '0;
    end else if ((ZERO_R0 != 0) && (addr == '0)) begin
      r = {1'b1, {WIDTH{1'b0}}};
    end else if ((BYPASS != 0) && wr && (addr == wa)) begin
      r = {1'b1, wd};
    end else begin
      r = {vbit, word};
    end
    return r;
  endfunction

  // A write to the hard-zero word is dropped; wr_ok also gates forwarding.
  assign wr_ok = we && !((ZERO_R0 != 0) && (waddr == '0));

  // Next-load values for both read ports.
  always_comb begin
    next_a = lookup(raddr_a, mem[raddr_a], valid[raddr_a], wr_ok, waddr, wdata, clr);
    next_b = lookup(raddr_b, mem[raddr_b], valid[raddr_b], wr_ok, waddr, wdata, clr);
  end

  // Storage and valid bits: reset and clear wipe everything and swallow the write.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else if (wr_ok) begin
      mem[waddr]   <= wdata;
      valid[waddr] <= 1'b1;
    end
  end

  // Read output registers: load on ren, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a  <= '0;
      rvalid_a <= 1'b0;
      rdata_b  <= '0;
      rvalid_b <= 1'b0;
    end else begin
      if (ren_a) begin
        {rvalid_a, rdata_a} <= next_a;
      end
      if (ren_b) begin
        {rvalid_b, rdata_b} <= next_b;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - self-checking bench for reg_file_param
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic        ren_a = 1'b0;
  logic [2:0]  raddr_a = '0;
  logic        ren_b = 1'b0;
  logic [2:0]  raddr_b = '0;

  logic [15:0] m_rdata_a, m_rdata_b, n_rdata_a, n_rdata_b, z_rdata_a, z_rdata_b;
  logic        m_rvalid_a, m_rvalid_b, n_rvalid_a, n_rvalid_b, z_rvalid_a, z_rvalid_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_file_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .ZERO_R0(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(m_rdata_a), .rvalid_a(m_rvalid_a),
    .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(m_rdata_b), .rvalid_b(m_rvalid_b)
  );

  reg_file_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(0), .ZERO_R0(0)) dut_nb (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(n_rdata_a), .rvalid_a(n_rvalid_a),
    .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(n_rdata_b), .rvalid_b(n_rvalid_b)
  );

  reg_file_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .ZERO_R0(1)) dut_z (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(z_rdata_a), .rvalid_a(z_rvalid_a),
    .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(z_rdata_b), .rvalid_b(z_rvalid_b)
  );

  typedef struct {
    logic        rst, clr, we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        ren_a;
    logic [2:0]  raddr_a;
    logic        ren_b;
    logic [2:0]  raddr_b;
    logic [15:0] ea_d;
    logic        ea_v;
    logic [15:0] eb_d;
    logic        eb_v;
  } vec_t;

  typedef struct {
    int          idx;
    logic [33:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  task automatic add(input logic r, input logic c, input logic w, input logic [2:0] wa,
                     input logic [15:0] wd, input logic ra, input logic [2:0] aa,
                     input logic rb, input logic [2:0] ab,
                     input logic [15:0] ead, input logic eav,
                     input logic [15:0] ebd, input logic ebv);
    vec_t v;
    v.rst = r; v.clr = c; v.we = w; v.waddr = wa; v.wdata = wd;
    v.ren_a = ra; v.raddr_a = aa; v.ren_b = rb; v.raddr_b = ab;
    v.ea_d = ead; v.ea_v = eav; v.eb_d = ebd; v.eb_v = ebv;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic c, input logic w, input logic [2:0] wa,
                       input logic [15:0] wd, input logic ra, input logic [2:0] aa,
                       input logic rb, input logic [2:0] ab);
    rst = r; clr = c; we = w; waddr = wa; wdata = wd;
    ren_a = ra; raddr_a = aa; ren_b = rb; raddr_b = ab;
  endtask

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic compare_pop();
    sb_t e;
    e = sb.pop_front();
    chk($sformatf("vec%0d {a_d,a_v,b_d,b_v}", e.idx),
        {m_rdata_a, m_rvalid_a, m_rdata_b, m_rvalid_b}, e.exp);
  endtask

  // Drive one cycle of inputs, then advance to the next negedge so the
  // result of that edge can be sampled.
  task automatic step(input logic r, input logic c, input logic w, input logic [2:0] wa,
                      input logic [15:0] wd, input logic ra, input logic [2:0] aa,
                      input logic rb, input logic [2:0] ab);
    drive(r, c, w, wa, wd, ra, aa, rb, ab);
    @(negedge clk);
  endtask

  initial begin
    // Expected values are for the BYPASS=1, ZERO_R0=0 instance.
    //  rst clr we wa  wdata     ra aa  rb ab   a_d       a_v  b_d       b_v
    add(1, 0, 0, 0, 16'd0,     0, 0,  0, 0,   16'd0,    0,   16'd0,    0);
    add(1, 0, 0, 0, 16'd0,     0, 0,  0, 0,   16'd0,    0,   16'd0,    0);
    for (int i = 0; i < 8; i++) begin
      add(0, 0, 0, 0, 16'd0,   1, 3'(i), 1, 3'(7 - i), 16'd0, 0, 16'd0, 0);
    end
    add(0, 0, 1, 3, 16'd15,    0, 0,  0, 0,   16'd0,    0,   16'd0,    0);
    add(0, 0, 0, 0, 16'd0,     1, 3,  1, 4,   16'd15,   1,   16'd0,    0);
    add(0, 0, 1, 5, 16'd400,   0, 0,  1, 5,   16'd15,   1,   16'd400,  1);
    add(0, 0, 0, 0, 16'd0,     1, 3,  0, 0,   16'd15,   1,   16'd400,  1);
    add(0, 0, 1, 3, 16'd77,    0, 3,  0, 0,   16'd15,   1,   16'd400,  1);
    add(0, 0, 0, 0, 16'd0,     0, 3,  0, 0,   16'd15,   1,   16'd400,  1);
    add(0, 0, 0, 0, 16'd0,     0, 3,  0, 0,   16'd15,   1,   16'd400,  1);
    add(0, 0, 0, 0, 16'd0,     1, 3,  0, 0,   16'd77,   1,   16'd400,  1);
    add(0, 0, 1, 2, 16'd50,    0, 0,  0, 0,   16'd77,   1,   16'd400,  1);
    add(0, 1, 1, 6, 16'd35,    1, 2,  0, 0,   16'd0,    0,   16'd400,  1);
    add(0, 0, 0, 0, 16'd0,     1, 2,  1, 6,   16'd0,    0,   16'd0,    0);
    add(0, 0, 0, 0, 16'd0,     1, 5,  1, 3,   16'd0,    0,   16'd0,    0);
    add(0, 0, 1, 7, 16'hffff,  1, 7,  1, 7,   16'hffff, 1,   16'hffff, 1);
    add(0, 0, 1, 7, 16'h1234,  1, 7,  0, 7,   16'h1234, 1,   16'hffff, 1);
    add(0, 0, 0, 0, 16'd0,     0, 7,  1, 7,   16'h1234, 1,   16'h1234, 1);
    add(1, 0, 1, 1, 16'haaaa,  1, 1,  1, 1,   16'd0,    0,   16'd0,    0);
    add(0, 0, 0, 0, 16'd0,     1, 1,  1, 7,   16'd0,    0,   16'd0,    0);
    add(0, 0, 1, 0, 16'habcd,  1, 0,  1, 0,   16'habcd, 1,   16'habcd, 1);

    foreach (vecs[i]) begin
      sb_t e;
      @(negedge clk);
      if (sb.size() > 0) compare_pop();
      drive(vecs[i].rst, vecs[i].clr, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
            vecs[i].ren_a, vecs[i].raddr_a, vecs[i].ren_b, vecs[i].raddr_b);
      e.idx = i;
      e.exp = {vecs[i].ea_d, vecs[i].ea_v, vecs[i].eb_d, vecs[i].eb_v};
      sb.push_back(e);
    end
    @(negedge clk);
    compare_pop();

    // Non-bypass and hard-zero instances, same shared stimulus.
    step(1, 0, 0, 0, 16'd0,   0, 0, 0, 0);
    chk("z reset a", {18'd0, z_rdata_a, z_rvalid_a}, {18'd0, 16'd0, 1'b0});
    step(0, 0, 1, 5, 16'd400, 1, 0, 1, 5);
    chk("nb rdw b",   {18'd0, n_rdata_b, n_rvalid_b}, {18'd0, 16'd0, 1'b0});
    chk("byp rdw b",  {18'd0, m_rdata_b, m_rvalid_b}, {18'd0, 16'd400, 1'b1});
    chk("z r0 a",     {18'd0, z_rdata_a, z_rvalid_a}, {18'd0, 16'd0, 1'b1});
    chk("nb r0 a",    {18'd0, n_rdata_a, n_rvalid_a}, {18'd0, 16'd0, 1'b0});
    step(0, 0, 0, 0, 16'd0,   0, 0, 1, 5);
    chk("nb reread b", {18'd0, n_rdata_b, n_rvalid_b}, {18'd0, 16'd400, 1'b1});
    step(0, 0, 1, 0, 16'd35,  1, 0, 0, 0);
    chk("z wr0 rdw a", {18'd0, z_rdata_a, z_rvalid_a}, {18'd0, 16'd0, 1'b1});
    chk("byp wr0 a",   {18'd0, m_rdata_a, m_rvalid_a}, {18'd0, 16'd35, 1'b1});
    chk("nb wr0 a",    {18'd0, n_rdata_a, n_rvalid_a}, {18'd0, 16'd0, 1'b0});
    step(0, 0, 0, 0, 16'd0,   1, 0, 0, 0);
    chk("z r0 after wr", {18'd0, z_rdata_a, z_rvalid_a}, {18'd0, 16'd0, 1'b1});
    chk("nb r0 after wr", {18'd0, n_rdata_a, n_rvalid_a}, {18'd0, 16'd35, 1'b1});
    step(0, 0, 1, 1, 16'd35,  0, 0, 1, 1);
    chk("z wr1 rdw b", {18'd0, z_rdata_b, z_rvalid_b}, {18'd0, 16'd35, 1'b1});
    step(0, 0, 0, 0, 16'd0,   0, 0, 1, 1);
    chk("z r1 b",      {18'd0, z_rdata_b, z_rvalid_b}, {18'd0, 16'd35, 1'b1});
    step(0, 1, 0, 0, 16'd0,   1, 0, 0, 0);
    chk("z clr r0 a",  {18'd0, z_rdata_a, z_rvalid_a}, {18'd0, 16'd0, 1'b0});
    chk("z clr hold b", {18'd0, z_rdata_b, z_rvalid_b}, {18'd0, 16'd35, 1'b1});
    step(0, 0, 0, 0, 16'd0,   1, 0, 1, 1);
    chk("z r0 post clr", {18'd0, z_rdata_a, z_rvalid_a}, {18'd0, 16'd0, 1'b1});
    chk("z r1 post clr", {18'd0, z_rdata_b, z_rvalid_b}, {18'd0, 16'd0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised register file: DEPTH words of WIDTH bits, one write port, two independent registered read ports. Tracks a per-word valid bit ("written since reset/clear") and has an optional hard-zero register 0. Generalises the single enabled 16-bit storage register into an addressable bank used by the datapath for operand storage.

Parameters:
WIDTH, 16, data width of each word
ADDR_W, 3, address width; DEPTH = 2**ADDR_W words (8 by default)
BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = read returns pre-write contents
ZERO_R0, 0, 1 = word 0 is hardwired to zero, always valid, and ignores writes

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
clr  in  1  synchronous clear of all words and valid bits
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  WIDTH  write data
ren_a  in  1  read enable, port A
raddr_a  in  ADDR_W  read address, port A
rdata_a  out  WIDTH  registered read data, port A
rvalid_a  out  1  registered valid bit of the word read on port A
ren_b  in  1  read enable, port B
raddr_b  in  ADDR_W  read address, port B
rdata_b  out  WIDTH  registered read data, port B
rvalid_b  out  1  registered valid bit of the word read on port B

Behaviour:
- Everything updates on the rising edge of clk only. There are no asynchronous paths.
- Priority order: rst > clr > we.
- rst=1:
  - All words become 0 and all valid bits become 0.
  - rdata_a, rdata_b, rvalid_a and rvalid_b all become 0.
  - Reset asserted mid-operation discards any write presented in that cycle.
- clr=1 (rst=0):
  - Same effect on storage and valid bits as rst.
  - Any we in that cycle is ignored.
  - A port with ren=1 in that cycle loads rdata=0 and rvalid=0. A port with ren=0 holds its outputs.
- Write (we=1, rst=0, clr=0): mem[waddr] <= wdata and valid[waddr] <= 1.
  - Exception: when ZERO_R0=1 and waddr=0, the write is ignored.
- Read latency is 1 cycle. When ren_x=1 at an edge, rdata_x and rvalid_x load mem[raddr_x] and valid[raddr_x].
  - When ren_x=0, rdata_x and rvalid_x hold their previous values.
- Read-during-write (we=1, ren_x=1, raddr_x=waddr, no rst/clr):
  - BYPASS=1: rdata_x loads wdata and rvalid_x loads 1.
  - BYPASS=0: rdata_x and rvalid_x load the pre-write contents.
  - Either way, storage updates as normal.
  - With ZERO_R0=1 and address 0, no forwarding occurs.
- ZERO_R0=1: reads of address 0 return rdata=0 and rvalid=1 at all times after reset.
  - Exception: in a cycle with rst or clr active, the outputs load 0/0 per the rules above.
- Both ports may read the same address in the same cycle, each with identical results.
- All address values are legal because DEPTH=2**ADDR_W; there is no error path.
- Storage is plain flops or inferred distributed RAM; the synchronous clear must be honoured either way.
- The block has no state machine beyond storage plus valid bits; all behaviour is per-edge.

Test Plan:
1. Reset: rst=1 for 2 cycles, then read addresses 0..7 on both ports with ren=1 -> rdata=0 and rvalid=0 for all, one cycle after each address is presented.
2. Write/read: we=1, waddr=3, wdata=15; next cycle ren_a=1, raddr_a=3 -> one edge later rdata_a=15 and rvalid_a=1, while address 4 reads 0/0.
3. Bypass: in one cycle we=1, waddr=5, wdata=400, ren_b=1, raddr_b=5.
   - BYPASS=1 instance: rdata_b=400, rvalid_b=1.
   - BYPASS=0 instance: rdata_b=0, rvalid_b=0; re-reading next cycle gives 400/1.
4. Hold: read address 3 -> 15. Then set ren_a=0 and write 77 to address 3 -> rdata_a stays 15 for 3 cycles. Set ren_a=1 -> rdata_a=77.
5. Clear priority: write 50 to address 2, then in one cycle assert clr=1 with we=1, waddr=6, wdata=35 -> reads of addresses 2 and 6 both return 0/0.
6. ZERO_R0=1: we=1, waddr=0, wdata=35; then read address 0 -> rdata=0, rvalid=1. Writing 35 to address 1 and reading it back -> 35/1.
